stk_pipe_mem_prev_ctrl: RTL and testbench
=========================================

Name: stk_pipe_mem_prev_ctrl

Overview:
- Initiator/controller for the 1024x12 single-port "prev" pointer SRAM in the stack pipe.
- Accepts independent write and read request streams from pipe logic and arbitrates them onto the single RW port.
- Issues SRAM addr/din/ce/oe and captures the 1-cycle-latency read data into a backpressurable response FIFO.
- Read requesters are guaranteed forward progress under sustained write traffic.

Parameters:
- W, 12, data width; must match the SRAM word.
- N, 1024, SRAM depth; address width AW = $clog2(N) = 10.
- WR_BURST_MAX, 4, max consecutive write grants while a read is pending; 1..15.
- RSP_DEPTH, 2, response FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- i_wr_vld  in  1  write request valid.
- i_wr_addr  in  AW  write address.
- i_wr_data  in  W  write data.
- o_wr_rdy  out  1  write accepted when i_wr_vld & o_wr_rdy.
- i_rd_vld  in  1  read request valid.
- i_rd_addr  in  AW  read address.
- o_rd_rdy  out  1  read accepted when i_rd_vld & o_rd_rdy.
- o_rsp_vld  out  1  response valid.
- o_rsp_addr  out  AW  address of returned data.
- o_rsp_data  out  W  read data.
- i_rsp_rdy  in  1  response consumed when o_rsp_vld & i_rsp_rdy.
- o_sram_addr  out  AW  SRAM address.
- o_sram_din  out  W  SRAM write data.
- o_sram_ce  out  1  SRAM chip enable.
- o_sram_oe  out  1  1 = read, 0 = write (when ce = 1).
- i_sram_dout  in  W  SRAM read data, valid the cycle after a read issue.
- o_busy  out  1  init in progress, read in flight, or FIFO non-empty.

Behaviour:
- Reset (async assert, sync deassert usage): o_sram_ce=0, o_sram_oe=0, o_rsp_vld=0, o_wr_rdy=0, o_rd_rdy=0, o_busy=0 (1 if INIT compiled in); FIFO empty; starvation counter=0; inflight=0.
- SRAM port: at most one access per cycle. A grant drives ce=1 combinationally in the same cycle as the accepting handshake. addr/din/oe reflect the granted request; when idle, ce=0 and addr/din hold their last value.
- Credit: credit = RSP_DEPTH - fifo_count - inflight. o_rd_rdy requires credit > 0. A FIFO pop in the current cycle does not add credit until the next cycle.
- Arbitration in state RUN:
  - Write wins by default.
  - Read wins when wr_cnt == WR_BURST_MAX and a read is valid with credit.
  - wr_cnt increments on each write grant while i_rd_vld=1, saturating at WR_BURST_MAX.
  - wr_cnt clears on a read grant or when i_rd_vld=0.
  - The loser's rdy is 0 in that cycle.
  - A read with no credit never blocks a write.
- Read latency: a read granted in cycle T sets inflight. In T+1, i_sram_dout and the latched address are pushed to the FIFO. o_rsp_vld is 1 from T+2 (registered FIFO output), so 2-cycle minimum read-to-response.
- Ordering: responses are in read-grant order. A read following a write to the same address returns the new data (single port serialises them; no bypass needed). A read and a write to the same address presented in the same cycle: the write is granted first, so the read returns the new data.
- FIFO: simultaneous push and pop is allowed at any occupancy including full (push needs a credit, so there is never overflow). Pointers wrap modulo RSP_DEPTH.
- o_rsp_* is stable while o_rsp_vld & ~i_rsp_rdy.
- Reset mid-operation: the in-flight read is discarded, the FIFO is emptied, and ce drops asynchronously.
- FSM: INIT -> RUN. INIT is present only with the optional feature; otherwise the block resets directly into RUN.

Optional Feature:
- Macro: STK_PIPE_MEM_PREV_CTRL_INIT_EN.
- When defined, the block resets into INIT:
  - A 10-bit counter sweeps addresses 0..N-1, one write per cycle with din = {W{1'b0}}, ce=1, oe=0.
  - o_wr_rdy = o_rd_rdy = 0 and o_busy = 1 throughout the sweep.
  - After the write to N-1 (N cycles after reset deassert), the FSM enters RUN.
- When undefined: no INIT state and no counter; the SRAM contents are undefined until written.

Test Plan:
- Write addr 0x005 data 0xABC, then read 0x005 -> o_rsp_vld 2 cycles after the read grant, o_rsp_data=0xABC, o_rsp_addr=0x005.
- Same-cycle write 0x010=0x123 and read 0x010 -> write granted first, read granted next cycle, response data=0x123.
- Continuous writes plus a pending read with WR_BURST_MAX=4 -> read granted in cycle 5 (after exactly 4 writes), writes resume on cycle 6.
- Hold i_rsp_rdy=0 and issue 3 reads -> exactly 2 accepted, o_rd_rdy=0 thereafter. Raising i_rsp_rdy drains the responses in order and allows the third read.
- Assert arst_n low with a read in flight and 1 FIFO entry -> o_rsp_vld=0 and o_sram_ce=0 immediately, with no stale response after release.
- With STK_PIPE_MEM_PREV_CTRL_INIT_EN: after reset, 1024 ce=1/oe=0 writes of 0 occur. A read of 0x3FF in RUN returns 0x000. o_wr_rdy=0 during cycles 0..1023.

Source files
------------

// File: rtl/stk_pipe_mem_prev_ctrl.sv
// stk_pipe_mem_prev_ctrl: arbitrates write/read requests onto the 1024x12 "prev" pointer SRAM port and queues read responses.
// Optional build macro: STK_PIPE_MEM_PREV_CTRL_INIT_EN (zero-fill sweep of the SRAM after reset).
// Ports:
//   clk, arst_n                              clock, asynchronous active-low reset
//   i_wr_vld/i_wr_addr/i_wr_data/o_wr_rdy    write request stream
//   i_rd_vld/i_rd_addr/o_rd_rdy              read request stream
//   o_rsp_vld/o_rsp_addr/o_rsp_data/i_rsp_rdy read response stream (FIFO output)
//   o_sram_addr/o_sram_din/o_sram_ce/o_sram_oe/i_sram_dout  SRAM RW port
//   o_busy                                   init sweep, read in flight, or responses queued
module stk_pipe_mem_prev_ctrl #(
  parameter int W = 12,
  parameter int N = 1024,
  parameter int WR_BURST_MAX = 4,
  parameter int RSP_DEPTH = 2,
  localparam int AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_wr_vld,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  output logic          o_wr_rdy,
  input  logic          i_rd_vld,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rd_rdy,
  output logic          o_rsp_vld,
  output logic [AW-1:0] o_rsp_addr,
  output logic [W-1:0]  o_rsp_data,
  input  logic          i_rsp_rdy,
  output logic [AW-1:0] o_sram_addr,
  output logic [W-1:0]  o_sram_din,
  output logic          o_sram_ce,
  output logic          o_sram_oe,
  input  logic [W-1:0]  i_sram_dout,
  output logic          o_busy
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  logic          init, run;
  logic [AW-1:0] init_addr;
`ifdef STK_PIPE_MEM_PREV_CTRL_INIT_EN
  typedef enum logic {INIT, RUN} state_e;
  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + AW'(1);
      if (init_cnt_q == AW'(N - 1)) state_q <= RUN;
    end
  assign init      = state_q == INIT;
  assign init_addr = init_cnt_q;
`else
  assign init      = 1'b0;
  assign init_addr = '0;
`endif
  logic [CW-1:0]      cnt_q;
  logic [PW-1:0]      wp_q, rp_q;
  logic [AW+W-1:0]    mem_q [RSP_DEPTH];
  logic               inflight_q;
  logic [3:0]         wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]      addr_q;
  logic [W-1:0]       din_q;
  logic               credit, burst_full, wr_gnt, rd_gnt, push, pop;
  // reset gates the grants directly so ce and both rdy drop the moment arst_n falls
  assign run        = arst_n & ~init;
  assign credit     = (cnt_q + CW'(inflight_q)) < CW'(RSP_DEPTH);
  assign burst_full = wr_cnt_q == 4'(WR_BURST_MAX);
  assign o_wr_rdy   = run & ~(burst_full & i_rd_vld & credit);
  assign o_rd_rdy   = run & credit & (burst_full | ~i_wr_vld);
  assign wr_gnt     = i_wr_vld & o_wr_rdy;
  assign rd_gnt     = i_rd_vld & o_rd_rdy;
  assign o_sram_ce  = wr_gnt | rd_gnt | (init & arst_n);
  assign o_sram_oe  = rd_gnt;
  assign o_sram_addr = init ? init_addr : rd_gnt ? i_rd_addr : wr_gnt ? i_wr_addr : addr_q;
  assign o_sram_din  = init ? '0 : wr_gnt ? i_wr_data : din_q;
  assign wr_cnt_d   = (rd_gnt | ~i_rd_vld) ? 4'd0 : (wr_gnt & ~burst_full) ? wr_cnt_q + 4'd1 : wr_cnt_q;
  // the read address is still held in addr_q during the data-return cycle
  assign push       = inflight_q;
  assign pop        = o_rsp_vld & i_rsp_rdy;
  assign o_rsp_vld  = cnt_q != '0;
  assign {o_rsp_addr, o_rsp_data} = mem_q[rp_q];
  assign o_busy     = init | inflight_q | o_rsp_vld;
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      cnt_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      inflight_q <= 1'b0;
      wr_cnt_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
    end else begin
      cnt_q      <= cnt_q + CW'(push) - CW'(pop);
      wp_q       <= wp_q + PW'(push);
      rp_q       <= rp_q + PW'(pop);
      inflight_q <= rd_gnt;
      wr_cnt_q   <= wr_cnt_d;
      if (o_sram_ce) begin
        addr_q <= o_sram_addr;
        din_q  <= o_sram_din;
      end
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {addr_q, i_sram_dout};
endmodule

// File: tb/tb_stk_pipe_mem_prev_ctrl.sv
// tb_stk_pipe_mem_prev_ctrl: directed table, corner sequences and randomized traffic against a queue-based reference model.
module tb_stk_pipe_mem_prev_ctrl;
  localparam int W = 12, N = 1024, AW = 10, BM = 4, RD = 2;
`ifdef STK_PIPE_MEM_PREV_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif
  logic clk = 1'b0, arst_n = 1'b0;
  logic i_wr_vld = 1'b0, i_rd_vld = 1'b0, i_rsp_rdy = 1'b0;
  logic [AW-1:0] i_wr_addr = '0, i_rd_addr = '0;
  logic [W-1:0] i_wr_data = '0;
  logic o_wr_rdy, o_rd_rdy, o_rsp_vld, o_sram_ce, o_sram_oe, o_busy;
  logic [AW-1:0] o_rsp_addr, o_sram_addr;
  logic [W-1:0] o_rsp_data, o_sram_din, i_sram_dout;
  logic [W-1:0] ram [N];
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  stk_pipe_mem_prev_ctrl dut (
    .clk(clk), .arst_n(arst_n),
    .i_wr_vld(i_wr_vld), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
    .i_rd_vld(i_rd_vld), .i_rd_addr(i_rd_addr), .o_rd_rdy(o_rd_rdy),
    .o_rsp_vld(o_rsp_vld), .o_rsp_addr(o_rsp_addr), .o_rsp_data(o_rsp_data), .i_rsp_rdy(i_rsp_rdy),
    .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din), .o_sram_ce(o_sram_ce), .o_sram_oe(o_sram_oe),
    .i_sram_dout(i_sram_dout), .o_busy(o_busy)
  );

  always @(posedge clk)
    if (o_sram_ce) begin
      if (o_sram_oe) i_sram_dout <= ram[o_sram_addr];
      else ram[o_sram_addr] = o_sram_din;
    end

  typedef struct { logic [AW-1:0] a; logic [W-1:0] d; int t; } rsp_t;
  rsp_t q[$];
  logic [W-1:0] ref_mem [N];
  int cyc_n, burst, init_left, init_idx;
  logic [AW-1:0] last_a;
  logic [W-1:0] last_d;
  logic obs_wg, obs_rg, obs_wr_rdy, obs_rd_rdy, obs_ce, obs_oe, obs_vld;
  logic [AW-1:0] obs_ra, obs_addr;
  logic [W-1:0] obs_rdat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic mdl_reset();
    q.delete();
    burst = 0;
    last_a = '0;
    last_d = '0;
    cyc_n = 0;
    init_left = INIT_EN ? N : 0;
    init_idx = 0;
  endtask

  task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra, input logic rr);
    i_wr_vld = wv; i_wr_addr = wa; i_wr_data = wd;
    i_rd_vld = rv; i_rd_addr = ra; i_rsp_rdy = rr;
  endtask

  // one clock: compare the DUT against the model at negedge, advance the model at posedge
  task automatic cyc();
    bit e_wr, e_rd, wg, rg, vis, ini;
    int cr;
    logic [AW-1:0] ea;
    logic [W-1:0] ed;
    @(negedge clk);
    ini = init_left > 0;
    cr = RD - q.size();
    vis = q.size() > 0 && q[0].t <= cyc_n;
    e_wr = !ini && !(burst == BM && i_rd_vld && cr > 0);
    e_rd = !ini && cr > 0 && !(i_wr_vld && burst < BM);
    wg = i_wr_vld && e_wr;
    rg = i_rd_vld && e_rd;
    ea = ini ? AW'(init_idx) : rg ? i_rd_addr : wg ? i_wr_addr : last_a;
    ed = ini ? '0 : wg ? i_wr_data : last_d;
    chk("wr_rdy", o_wr_rdy, e_wr);
    chk("rd_rdy", o_rd_rdy, e_rd);
    chk("sram_ce", o_sram_ce, wg || rg || ini);
    chk("sram_oe", o_sram_oe, rg);
    chk("sram_addr", o_sram_addr, ea);
    chk("sram_din", o_sram_din, ed);
    chk("rsp_vld", o_rsp_vld, vis);
    if (vis) begin
      chk("rsp_addr", o_rsp_addr, q[0].a);
      chk("rsp_data", o_rsp_data, q[0].d);
    end
    chk("busy", o_busy, ini || q.size() > 0);
    obs_wg = o_wr_rdy & i_wr_vld; obs_rg = o_rd_rdy & i_rd_vld;
    obs_wr_rdy = o_wr_rdy; obs_rd_rdy = o_rd_rdy;
    obs_ce = o_sram_ce; obs_oe = o_sram_oe; obs_addr = o_sram_addr;
    obs_vld = o_rsp_vld; obs_ra = o_rsp_addr; obs_rdat = o_rsp_data;
    @(posedge clk);
    if (ini) begin
      ref_mem[init_idx] = '0; last_a = AW'(init_idx); last_d = '0;
      init_idx++; init_left--;
    end
    if (wg) begin ref_mem[i_wr_addr] = i_wr_data; last_a = i_wr_addr; last_d = i_wr_data; end
    if (rg) begin q.push_back('{i_rd_addr, ref_mem[i_rd_addr], cyc_n + 2}); last_a = i_rd_addr; end
    if (vis && i_rsp_rdy) void'(q.pop_front());
    burst = (rg || !i_rd_vld) ? 0 : (wg && burst < BM) ? burst + 1 : burst;
    cyc_n++;
    #1;
  endtask

  task automatic run_init();
    int nw = 0;
    while (init_left > 0) begin
      drive(1'b1, 10'h3AA, 12'h555, 1'b1, 10'h3AA, 1'b1);
      cyc();
      if (obs_ce && !obs_oe && obs_addr == AW'(init_idx - 1)) nw++;
    end
    if (INIT_EN) chk("init_writes", nw, N);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
  endtask

  typedef struct {
    logic wv; logic [AW-1:0] wa; logic [W-1:0] wd; logic rv; logic [AW-1:0] ra; logic rr;
    logic ewr, erd, ece, eoe, evld; logic [AW-1:0] era; logic [W-1:0] edat;
  } vec_t;
  vec_t tv[9];

  initial begin
    int acc;
    logic [AW-1:0] pq[$];
    bit g3, seen;
    for (int i = 0; i < N; i++) begin ram[i] = 12'hFFF; ref_mem[i] = 12'hFFF; end
    tv[0] = '{1'b1, 10'h005, 12'hABC, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 12'h000};
    tv[1] = '{1'b0, 10'h000, 12'h000, 1'b1, 10'h005, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 12'h000};
    tv[2] = '{1'b0, 10'h000, 12'h000, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000};
    tv[3] = '{1'b0, 10'h000, 12'h000, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h005, 12'hABC};
    tv[4] = '{1'b1, 10'h010, 12'h123, 1'b1, 10'h010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 12'h000};
    tv[5] = '{1'b0, 10'h000, 12'h000, 1'b1, 10'h010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 10'h000, 12'h000};
    tv[6] = '{1'b0, 10'h000, 12'h000, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000};
    tv[7] = '{1'b0, 10'h000, 12'h000, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 10'h010, 12'h123};
    tv[8] = '{1'b0, 10'h000, 12'h000, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 12'h000};

    mdl_reset();
    drive(1'b1, 10'h001, 12'h001, 1'b1, 10'h001, 1'b1);
    #2;
    chk("rst_ce", o_sram_ce, 1'b0);
    chk("rst_oe", o_sram_oe, 1'b0);
    chk("rst_wr_rdy", o_wr_rdy, 1'b0);
    chk("rst_rd_rdy", o_rd_rdy, 1'b0);
    chk("rst_rsp_vld", o_rsp_vld, 1'b0);
    chk("rst_busy", o_busy, INIT_EN);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    run_init();

`ifdef STK_PIPE_MEM_PREV_CTRL_INIT_EN
    g3 = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, '0, !g3, 10'h3FF, 1'b1);
      cyc();
      if (obs_rg) g3 = 1'b1;
      if (obs_vld && obs_ra == 10'h3FF) begin seen = 1'b1; chk("init_rd_3ff", obs_rdat, 12'h000); end
    end
    chk("init_rd_seen", seen, 1'b1);
`endif

    for (int i = 0; i < 9; i++) begin
      drive(tv[i].wv, tv[i].wa, tv[i].wd, tv[i].rv, tv[i].ra, tv[i].rr);
      cyc();
      chk($sformatf("tv%0d_wr_rdy", i), obs_wr_rdy, tv[i].ewr);
      chk($sformatf("tv%0d_rd_rdy", i), obs_rd_rdy, tv[i].erd);
      chk($sformatf("tv%0d_ce", i), obs_ce, tv[i].ece);
      chk($sformatf("tv%0d_oe", i), obs_oe, tv[i].eoe);
      chk($sformatf("tv%0d_rsp_vld", i), obs_vld, tv[i].evld);
      if (tv[i].evld) begin
        chk($sformatf("tv%0d_rsp_addr", i), obs_ra, tv[i].era);
        chk($sformatf("tv%0d_rsp_data", i), obs_rdat, tv[i].edat);
      end
    end

    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, AW'(10'h100 + k), W'(k), k <= 5, 10'h101, 1'b1);
      cyc();
      chk($sformatf("burst%0d_wgnt", k), obs_wg, k != 5);
      chk($sformatf("burst%0d_rgnt", k), obs_rg, k == 5);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (3) cyc();

    acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(10'h020 + acc), 1'b0);
      cyc();
      if (obs_rg) acc++;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_rd_rdy_low", obs_rd_rdy, 1'b0);
    g3 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b0, '0, '0, !g3, 10'h022, 1'b1);
      cyc();
      if (obs_vld) pq.push_back(obs_ra);
      if (obs_rg) g3 = 1'b1;
    end
    chk("bp_third_granted", g3, 1'b1);
    chk("bp_rsp_count", pq.size(), 3);
    foreach (pq[k]) chk($sformatf("bp_rsp%0d_addr", k), pq[k], AW'(10'h020 + k));

    drive(1'b0, '0, '0, 1'b1, 10'h030, 1'b0);
    cyc();
    cyc();
    drive(1'b1, 10'h040, 12'h040, 1'b0, '0, 1'b0);
    #1;
    chk("prerst_rsp_vld", o_rsp_vld, 1'b1);
    chk("prerst_busy", o_busy, 1'b1);
    arst_n = 1'b0;
    #1;
    chk("midrst_rsp_vld", o_rsp_vld, 1'b0);
    chk("midrst_ce", o_sram_ce, 1'b0);
    chk("midrst_wr_rdy", o_wr_rdy, 1'b0);
    chk("midrst_busy", o_busy, INIT_EN);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    arst_n = 1'b1;
    mdl_reset();
    run_init();
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (obs_vld) seen = 1'b1;
    end
    chk("postrst_no_stale", seen, 1'b0);

    for (int k = 0; k < 2000; k++) begin
      drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 15)), W'($urandom),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom_range(0, 9) < 6);
      cyc();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1);
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
